alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing control unit driving the 8-bit ALU from the issue side. It accepts one 32-bit instruction at a time over a valid/ready handshake and reads operands from an internal 8×8 register file. It presents DATA1, DATA2 and SELECT to the ALU, holds them for a programmable settle time, then writes the ALU RESULT back or resolves a branch from the ALU ZERO flag. It sits between instruction fetch and the ALU and owns all architectural register state.

## Interface
- EXEC_CYCLES, default 2: cycles operands are held on the ALU before RESULT/ZERO are sampled; legal range 1–15.
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  block can accept an instruction; high only in IDLE.
- instr  in  32  opcode[31:24], dest[23:16] (uses [2:0]), src1[15:8] (uses [2:0]), src2/imm[7:0] (src2 uses [2:0]).
- alu_data1  out  8  ALU DATA1.
- alu_data2  out  8  ALU DATA2.
- alu_select  out  3  ALU SELECT.
- alu_result  in  8  ALU RESULT.
- alu_zero  in  1  ALU ZERO.
- done  out  1  one-cycle pulse: instruction retired.
- illegal  out  1  one-cycle pulse coincident with done: opcode undefined.
- branch_taken  out  1  one-cycle pulse coincident with done: beq/bne taken.
- branch_offset  out  8  instr[23:16] of the retiring branch; valid while branch_taken is high.
- dbg_addr  in  3  debug register index.
- dbg_data  out  8  combinational read of register dbg_addr.

## Operation
- Opcodes and the ALU SELECT each one drives:
  - loadi 0x00: 000, d1=0, d2=imm.
  - mov 0x01: 000, d2=rf[src2].
  - add 0x02: 001.
  - sub 0x03: 001, d2=−rf[src2] (8-bit two's complement, wraps).
  - and 0x04: 010.
  - or 0x05: 011.
  - mul 0x06: 110.
  - sll 0x07: 100, d2=imm.
  - srl 0x08: 101, d2=imm.
  - ror 0x09: 111, d2=imm.
  - beq 0x0A: 001, d1=rf[src1], d2=−rf[src2].
  - bne 0x0B: same operands as beq.
  - Any other opcode is illegal.
- Unless listed otherwise, d1=rf[src1] and d2=rf[src2].
- FSM states:
  - IDLE: handshake (instr_valid & instr_ready) at a rising edge → EXEC. Operands, select and dest are captured from the register file read at that edge; exec counter loads EXEC_CYCLES−1.
  - EXEC: ALU outputs are held stable. Counter == 0 → WB; otherwise decrement.
  - WB: → IDLE, always.
- WB edge actions:
  - ALU-writing opcodes: rf[dest] ← alu_result.
  - beq: branch_taken = alu_zero.
  - bne: branch_taken = ~alu_zero.
  - Branches and illegal opcodes: no register write.
- Illegal opcode: traverses EXEC/WB normally. alu_select=000, data 0, illegal and done asserted, no side effects.
- A register read of dest in the same instruction observes the old value.
- instr is ignored when instr_ready is low; instr_valid may stay high across instructions.

## Timing
- Reset (asynchronous, RESET_N low):
  - State IDLE; all rf entries 0x00.
  - alu_data1, alu_data2, alu_select, done, illegal, branch_taken, branch_offset all 0.
  - instr_ready is 1, since it is decoded from IDLE.
- Latency from accept edge to done edge: EXEC_CYCLES+1 cycles. Throughput: one instruction per EXEC_CYCLES+2 cycles.
- done, illegal and branch_taken are registered. They are high for exactly the cycle following the WB edge, which is also the first IDLE cycle.
- The rf write is visible on dbg_data in the cycle done is high.
- Reset asserted mid-EXEC or mid-WB: the in-flight instruction is discarded, no write occurs, and no done pulse is generated.
- dbg_addr == dest during the WB cycle: dbg_data shows the old value until the edge.

## Structure
- Shared package `alu_issue_pkg` holds:
  - opcode localparams;
  - ALU select constants (SEL_FWD, SEL_ADD, SEL_AND, SEL_OR, SEL_SLL, SEL_SRL, SEL_MUL, SEL_ROR);
  - the FSM state encoding.
- Sub-module `reg_file_8x8`:
  - two combinational read ports plus the debug read port;
  - one synchronous write port (en, addr, data);
  - asynchronous active-low clear.
- Decode, operand mux and FSM live in `alu_issue_ctrl`.

## Test plan
- Load and add, EXEC_CYCLES=2, with a bench ALU model: loadi r1,0x05; loadi r2,0x03; add r3,r1,r2 → r3=0x08; done three cycles after each accept; throughput 4 cycles/instr.
- Subtraction wrap: r1=0x03, r2=0x05, sub r4,r1,r2 → alu_data2=0xFB, r4=0xFE.
- Branches: r1=r2=0x07.
  - beq offset=0x04 → branch_taken=1, branch_offset=0x04, no rf change.
  - bne, same operands → branch_taken=0.
- Handshake: instr_valid held high with 3 queued instructions → exactly 3 accepts, each only in IDLE; instr changes while not ready are ignored.
- Reset mid-EXEC: RESET_N pulsed low during add r5 → r5=0x00, no done, instr_ready=1 immediately.
- Illegal opcode 0x1F → done=1 and illegal=1 together, alu_select=000, all registers unchanged.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller.
// Holds the opcode map, the ALU SELECT codes, the FSM state encoding and the
// captured-instruction record that is held on the ALU during EXEC.
package alu_issue_pkg;

  // Opcodes, instr[31:24]
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_MUL   = 8'h06;
  localparam logic [7:0] OP_SLL   = 8'h07;
  localparam logic [7:0] OP_SRL   = 8'h08;
  localparam logic [7:0] OP_ROR   = 8'h09;
  localparam logic [7:0] OP_BEQ   = 8'h0A;
  localparam logic [7:0] OP_BNE   = 8'h0B;

  // ALU SELECT codes
  localparam logic [2:0] SEL_FWD = 3'b000;
  localparam logic [2:0] SEL_ADD = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_SLL = 3'b100;
  localparam logic [2:0] SEL_SRL = 3'b101;
  localparam logic [2:0] SEL_MUL = 3'b110;
  localparam logic [2:0] SEL_ROR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // What the WB edge does with the ALU outputs
  typedef enum logic [1:0] {
    RET_WRITE   = 2'd0,
    RET_BEQ     = 2'd1,
    RET_BNE     = 2'd2,
    RET_ILLEGAL = 2'd3
  } ret_kind_t;

  // Everything captured at the accept edge
  typedef struct packed {
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] sel;
    logic [2:0] dest;
    logic [7:0] offset;
    ret_kind_t  kind;
  } issue_t;

  // 8-bit two's complement negate (wraps: -0x00 = 0x00, -0x80 = 0x80)
  function automatic logic [7:0] neg8(input logic [7:0] v);
    return (~v) + 8'd1;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Issue-side bus of the ALU issue controller.
// Groups the instruction handshake, the ALU operand/result bus and the
// retire pulses. master = fetch/ALU side, slave = the controller.
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  alu_data1;
  logic [7:0]  alu_data2;
  logic [2:0]  alu_select;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        done;
  logic        illegal;
  logic        branch_taken;
  logic [7:0]  branch_offset;

  modport master (
    output instr_valid, instr, alu_result, alu_zero,
    input  instr_ready, alu_data1, alu_data2, alu_select,
           done, illegal, branch_taken, branch_offset
  );

  modport slave (
    input  instr_valid, instr, alu_result, alu_zero,
    output instr_ready, alu_data1, alu_data2, alu_select,
           done, illegal, branch_taken, branch_offset
  );
endinterface

// File: rtl/reg_file_8x8.sv
// 8 x 8-bit architectural register file.
// Ports: clk, rst_n (async active-low clear of all entries);
//        rd1/rd2/dbg combinational read ports (addr in, data out);
//        one synchronous write port (we, wr_addr, wr_data).
module reg_file_8x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rd1_addr,
  output logic [7:0] rd1_data,
  input  logic [2:0] rd2_addr,
  output logic [7:0] rd2_data,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data,
  input  logic       we,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data
);

  logic [7:0][7:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  mem <= '0;
    else if (we) mem[wr_addr] <= wr_data;
  end

  // Reads return the pre-edge value, so a same-cycle write is not bypassed
  assign rd1_data = mem[rd1_addr];
  assign rd2_data = mem[rd2_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side sequencer for the 8-bit ALU.
// Accepts one instruction over bus (valid/ready, ready only in IDLE), captures
// operands from the register file at the accept edge, holds them on the ALU
// for EXEC_CYCLES cycles, then writes RESULT back or resolves a branch on ZERO.
// Ports: CLK, RESET_N (async active-low); bus (slave modport: handshake,
//        ALU operands/result, done/illegal/branch pulses, branch_offset);
//        dbg_addr/dbg_data combinational register debug read.
// EXEC_CYCLES legal range 1..15.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int EXEC_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  alu_issue_ctrl_if.slave  bus,
  input  logic [2:0]       dbg_addr,
  output logic [7:0]       dbg_data
);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  issue_t     cur, dec;
  logic [7:0] rd1, rd2;
  logic       accept, wr_en;
  logic       done_q, illegal_q, taken_q;
  logic [7:0] offset_q;
  logic       unused_src1_hi;

  assign unused_src1_hi = ^bus.instr[15:11];

  assign accept = (state == ST_IDLE) && bus.instr_valid;
  assign wr_en  = (state == ST_WB) && (cur.kind == RET_WRITE);

  reg_file_8x8 u_rf (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .rd1_addr (bus.instr[10:8]),
    .rd1_data (rd1),
    .rd2_addr (bus.instr[2:0]),
    .rd2_data (rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wr_en),
    .wr_addr  (cur.dest),
    .wr_data  (bus.alu_result)
  );

  // Decode + operand mux, evaluated against the live instr; only latched on accept
  always_comb begin
    dec        = '0;
    dec.kind   = RET_WRITE;
    dec.sel    = SEL_FWD;
    dec.data1  = rd1;
    dec.data2  = rd2;
    dec.dest   = bus.instr[18:16];
    dec.offset = bus.instr[23:16];
    case (bus.instr[31:24])
      OP_LOADI: begin dec.data1 = 8'h00; dec.data2 = bus.instr[7:0]; end
      OP_MOV:   dec.sel = SEL_FWD;
      OP_ADD:   dec.sel = SEL_ADD;
      OP_SUB:   begin dec.sel = SEL_ADD; dec.data2 = neg8(rd2); end
      OP_AND:   dec.sel = SEL_AND;
      OP_OR:    dec.sel = SEL_OR;
      OP_MUL:   dec.sel = SEL_MUL;
      OP_SLL:   begin dec.sel = SEL_SLL; dec.data2 = bus.instr[7:0]; end
      OP_SRL:   begin dec.sel = SEL_SRL; dec.data2 = bus.instr[7:0]; end
      OP_ROR:   begin dec.sel = SEL_ROR; dec.data2 = bus.instr[7:0]; end
      // Branches compare by adding the negation; ZERO means equal
      OP_BEQ:   begin dec.sel = SEL_ADD; dec.data2 = neg8(rd2); dec.kind = RET_BEQ; end
      OP_BNE:   begin dec.sel = SEL_ADD; dec.data2 = neg8(rd2); dec.kind = RET_BNE; end
      default: begin
        dec.kind  = RET_ILLEGAL;
        dec.data1 = 8'h00;
        dec.data2 = 8'h00;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.instr_valid) state_nxt = ST_EXEC;
      ST_EXEC: if (cnt == 4'd0)     state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur       <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      taken_q   <= 1'b0;
      offset_q  <= '0;
    end else begin
      state     <= state_nxt;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      taken_q   <= 1'b0;
      if (accept) begin
        cur <= dec;
        cnt <= 4'(EXEC_CYCLES - 1);
      end else if (state == ST_EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ST_WB) begin
        done_q    <= 1'b1;
        illegal_q <= (cur.kind == RET_ILLEGAL);
        taken_q   <= ((cur.kind == RET_BEQ) &&  bus.alu_zero) ||
                     ((cur.kind == RET_BNE) && !bus.alu_zero);
        offset_q  <= (cur.kind == RET_BEQ || cur.kind == RET_BNE) ? cur.offset : 8'h00;
      end
    end
  end

  // Operands stay on the ALU after WB until the next accept replaces them
  assign bus.instr_ready   = (state == ST_IDLE);
  assign bus.alu_data1     = cur.data1;
  assign bus.alu_data2     = cur.data2;
  assign bus.alu_select    = cur.sel;
  assign bus.done          = done_q;
  assign bus.illegal       = illegal_q;
  assign bus.branch_taken  = taken_q;
  assign bus.branch_offset = offset_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  always #5 CLK = ~CLK;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.EXEC_CYCLES(2)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Bench ALU model
  logic [7:0] alu_res;
  always_comb begin
    alu_res = 8'h00;
    case (bus.alu_select)
      3'b000: alu_res = bus.alu_data2;
      3'b001: alu_res = bus.alu_data1 + bus.alu_data2;
      3'b010: alu_res = bus.alu_data1 & bus.alu_data2;
      3'b011: alu_res = bus.alu_data1 | bus.alu_data2;
      3'b100: alu_res = bus.alu_data1 << bus.alu_data2[2:0];
      3'b101: alu_res = bus.alu_data1 >> bus.alu_data2[2:0];
      3'b110: alu_res = bus.alu_data1 * bus.alu_data2;
      default: alu_res = 8'({bus.alu_data1, bus.alu_data1} >> bus.alu_data2[2:0]);
    endcase
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_zero   = (alu_res == 8'h00);

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int         last_acc, gap, lat;
  logic [7:0] ex_d1, ex_d2, wb_old, r_bo, r_dbg;
  logic [2:0] ex_sel;
  logic       r_ill, r_bt, seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one instruction and returns at the done negedge
  task automatic send(input logic [31:0] ins);
    int k = 0;
    while (!bus.instr_ready && k < 20) begin @(negedge CLK); k++; end
    bus.instr = ins; bus.instr_valid = 1'b1; dbg_addr = ins[18:16];
    @(posedge CLK);
    gap = cyc - last_acc; last_acc = cyc;
    #1 bus.instr_valid = 1'b0;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (lat == 0) begin ex_d1 = bus.alu_data1; ex_d2 = bus.alu_data2; ex_sel = bus.alu_select; end
      if (bus.done) begin
        seen = 1'b1; r_ill = bus.illegal; r_bt = bus.branch_taken;
        r_bo = bus.branch_offset; r_dbg = dbg_data;
        break;
      end
      wb_old = dbg_data;
      @(posedge CLK); lat++;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, d, s1, s2);
    return {op, d, s1, s2};
  endfunction

  int accepts, dones, idx;
  logic [31:0] q [3];
  logic [31:0] junk;
  logic        saw_done;

  initial begin
    bus.instr_valid = 1'b0; bus.instr = '0; dbg_addr = '0;
    repeat (2) @(negedge CLK);
    chk("rst_ready",  32'(bus.instr_ready), 32'd1);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_ill",    32'(bus.illegal), 32'd0);
    chk("rst_bt",     32'(bus.branch_taken), 32'd0);
    chk("rst_bo",     32'(bus.branch_offset), 32'd0);
    chk("rst_sel",    32'(bus.alu_select), 32'd0);
    chk("rst_d1",     32'(bus.alu_data1), 32'd0);
    chk("rst_d2",     32'(bus.alu_data2), 32'd0);
    for (int i = 0; i < 8; i++) begin dbg_addr = 3'(i); #1 chk("rst_rf", 32'(dbg_data), 32'd0); end
    RESET_N = 1'b1;
    @(negedge CLK);

    // load and add
    send(ins(8'h00, 8'h01, 8'h00, 8'h05));
    chk("loadi_lat", 32'(lat), 32'd3);
    chk("loadi_r1", 32'(r_dbg), 32'h05);
    chk("loadi_ill", 32'(r_ill), 32'd0);
    chk("loadi_bt", 32'(r_bt), 32'd0);
    send(ins(8'h00, 8'h02, 8'h00, 8'h03));
    chk("thru_gap", 32'(gap), 32'd4);
    chk("loadi2_lat", 32'(lat), 32'd3);
    send(ins(8'h02, 8'h03, 8'h01, 8'h02));
    chk("add_gap", 32'(gap), 32'd4);
    chk("add_d1", 32'(ex_d1), 32'h05);
    chk("add_d2", 32'(ex_d2), 32'h03);
    chk("add_sel", 32'(ex_sel), 32'd1);
    chk("add_wb_old", 32'(wb_old), 32'h00);
    chk("add_r3", 32'(r_dbg), 32'h08);

    // subtraction wrap
    send(ins(8'h00, 8'h01, 8'h00, 8'h03));
    send(ins(8'h00, 8'h02, 8'h00, 8'h05));
    send(ins(8'h03, 8'h04, 8'h01, 8'h02));
    chk("sub_d2", 32'(ex_d2), 32'hFB);
    chk("sub_sel", 32'(ex_sel), 32'd1);
    chk("sub_r4", 32'(r_dbg), 32'hFE);

    // branches, offset 0x04 aliases r4 in the dest field: must stay 0xFE
    send(ins(8'h00, 8'h01, 8'h00, 8'h07));
    send(ins(8'h00, 8'h02, 8'h00, 8'h07));
    send(ins(8'h0A, 8'h04, 8'h01, 8'h02));
    chk("beq_d2", 32'(ex_d2), 32'hF9);
    chk("beq_taken", 32'(r_bt), 32'd1);
    chk("beq_off", 32'(r_bo), 32'h04);
    chk("beq_nowr", 32'(r_dbg), 32'hFE);
    send(ins(8'h0B, 8'h04, 8'h01, 8'h02));
    chk("bne_taken", 32'(r_bt), 32'd0);
    chk("bne_nowr", 32'(r_dbg), 32'hFE);

    // handshake: valid held high, junk presented whenever not ready
    q[0] = ins(8'h00, 8'h05, 8'h00, 8'h11);
    q[1] = ins(8'h00, 8'h06, 8'h00, 8'h22);
    q[2] = ins(8'h02, 8'h00, 8'h05, 8'h06);
    junk = ins(8'h00, 8'h07, 8'h00, 8'hEE);
    accepts = 0; dones = 0; idx = 0;
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (idx < 3) begin
        if (bus.instr_ready) begin bus.instr = q[idx]; idx++; accepts++; end
        else bus.instr = junk;
      end else if (bus.instr_ready) begin
        bus.instr_valid = 1'b0;
      end else begin
        bus.instr = junk;
      end
      @(negedge CLK);
      if (bus.done) dones++;
    end
    bus.instr_valid = 1'b0;
    chk("hs_accepts", 32'(accepts), 32'd3);
    chk("hs_dones", 32'(dones), 32'd3);
    dbg_addr = 3'd5; #1 chk("hs_r5", 32'(dbg_data), 32'h11);
    dbg_addr = 3'd6; #1 chk("hs_r6", 32'(dbg_data), 32'h22);
    dbg_addr = 3'd0; #1 chk("hs_r0", 32'(dbg_data), 32'h33);
    dbg_addr = 3'd7; #1 chk("hs_r7_junk", 32'(dbg_data), 32'h00);

    // reset mid-EXEC
    @(negedge CLK);
    bus.instr = ins(8'h02, 8'h05, 8'h01, 8'h02); bus.instr_valid = 1'b1; dbg_addr = 3'd5;
    @(posedge CLK); #1 bus.instr_valid = 1'b0;
    @(negedge CLK);
    chk("mid_exec_ready", 32'(bus.instr_ready), 32'd0);
    RESET_N = 1'b0;
    #1 chk("rst_ready_now", 32'(bus.instr_ready), 32'd1);
    chk("rst_done_low", 32'(bus.done), 32'd0);
    @(negedge CLK); RESET_N = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin @(negedge CLK); if (bus.done) saw_done = 1'b1; end
    chk("rst_no_done", 32'(saw_done), 32'd0);
    chk("rst_r5", 32'(dbg_data), 32'h00);

    // illegal opcode
    send(ins(8'h00, 8'h01, 8'h00, 8'h5A));
    chk("ill_pre_ill", 32'(r_ill), 32'd0);
    send(ins(8'h1F, 8'h01, 8'h01, 8'h01));
    chk("ill_sel", 32'(ex_sel), 32'd0);
    chk("ill_d1", 32'(ex_d1), 32'd0);
    chk("ill_d2", 32'(ex_d2), 32'd0);
    chk("ill_flag", 32'(r_ill), 32'd1);
    chk("ill_bt", 32'(r_bt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk("ill_rf", 32'(dbg_data), (i == 1) ? 32'h5A : 32'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
